bp_fe_fill_arbiter: RTL and testbench

- Arbitrates the three LCE-to-I$ fill channels (data, tag and stat mem packets) onto a single registered fill port into the icache.
- Sits between the LCE packet outputs and the FE mem/icache fill logic.
- Uses round-robin grants to avoid starvation, a one-entry output holding register and a quiesce input so the FE can block fills while a fetch is in flight.
- Keeps a saturating grant counter for debug.

---
 rtl/bp_fe_fill_arbiter.sv | 126 ++++++++++++
 tb/tb_bp_fe_fill_arbiter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/bp_fe_fill_arbiter.sv
// bp_fe_fill_arbiter
// Merges the three LCE-to-I$ fill channels (data, tag and stat mem packets)
// onto one registered fill port. Grants rotate round-robin. A one-entry
// holding register drives the fill port. quiesce_i blocks new grants while
// still letting an already-held fill drain.
//
// Ports:
//   clk_i, reset_n_i            clock, asynchronous active-low reset
//   data_pkt_i/_v_i/_ready_o    data mem packet channel (ready = accept)
//   tag_pkt_i/_v_i/_ready_o     tag mem packet channel
//   stat_pkt_i/_v_i/_ready_o    stat mem packet channel
//   quiesce_i                   block new grants (fetch in flight)
//   fill_o, fill_type_o         held payload (zero-extended) and source type
//   fill_v_o, fill_ready_i      fill port handshake
//   grant_cnt_o                 saturating count of accepted packets
//   idle_o                      nothing held and no channel valid
module bp_fe_fill_arbiter #(
   parameter int data_pkt_width_p = 522,
   parameter int tag_pkt_width_p  = 40,
   parameter int stat_pkt_width_p = 12,
   parameter int cnt_width_p      = 16,
   localparam int fill_width_lp =
      (data_pkt_width_p > tag_pkt_width_p)
         ? ((data_pkt_width_p > stat_pkt_width_p) ? data_pkt_width_p : stat_pkt_width_p)
         : ((tag_pkt_width_p  > stat_pkt_width_p) ? tag_pkt_width_p  : stat_pkt_width_p)
) (
   input  logic                        clk_i,
   input  logic                        reset_n_i,
   input  logic [data_pkt_width_p-1:0] data_pkt_i,
   input  logic                        data_pkt_v_i,
   output logic                        data_pkt_ready_o,
   input  logic [tag_pkt_width_p-1:0]  tag_pkt_i,
   input  logic                        tag_pkt_v_i,
   output logic                        tag_pkt_ready_o,
   input  logic [stat_pkt_width_p-1:0] stat_pkt_i,
   input  logic                        stat_pkt_v_i,
   output logic                        stat_pkt_ready_o,
   input  logic                        quiesce_i,
   output logic [fill_width_lp-1:0]    fill_o,
   output logic [1:0]                  fill_type_o,
   output logic                        fill_v_o,
   input  logic                        fill_ready_i,
   output logic [cnt_width_p-1:0]      grant_cnt_o,
   output logic                        idle_o
);

   logic                     fill_v_reg;
   logic [1:0]               fill_type_reg;
   logic [fill_width_lp-1:0] fill_payload_reg;
   logic [1:0]               ptr_reg;
   logic [cnt_width_p-1:0]   cnt_reg;

   logic [2:0]               valid_vec;
   logic                     grant_en;
   logic                     grant_vld;
   logic [1:0]               grant_idx;
   logic                     grant;
   logic [fill_width_lp-1:0] sel_payload;

   assign valid_vec = {stat_pkt_v_i, tag_pkt_v_i, data_pkt_v_i};

   // The holding register may refill in the same cycle it drains.
   // reset_n_i is folded in so no accept can be signalled while in reset.
   assign grant_en = (~fill_v_reg | fill_ready_i) & ~quiesce_i & reset_n_i;

   // Scan p+2, p+1, p: the last valid hit is the highest-priority one.
   always_comb begin
      logic [2:0] idx;
      grant_vld = 1'b0;
      grant_idx = 2'd0;
      for (int k = 2; k >= 0; k--) begin
         idx = {1'b0, ptr_reg} + 3'(k);
         if (idx >= 3'd3) idx = idx - 3'd3;
         if (valid_vec[idx[1:0]]) begin
            grant_vld = 1'b1;
            grant_idx = idx[1:0];
         end
      end
   end

   assign grant = grant_vld & grant_en;

   assign data_pkt_ready_o = grant & (grant_idx == 2'd0);
   assign tag_pkt_ready_o  = grant & (grant_idx == 2'd1);
   assign stat_pkt_ready_o = grant & (grant_idx == 2'd2);

   // Casts zero-extend the narrower packets into the fill payload.
   always_comb begin
      sel_payload = '0;
      case (grant_idx)
         2'd0:    sel_payload = fill_width_lp'(data_pkt_i);
         2'd1:    sel_payload = fill_width_lp'(tag_pkt_i);
         2'd2:    sel_payload = fill_width_lp'(stat_pkt_i);
         default: sel_payload = '0;
      endcase
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         fill_v_reg       <= 1'b0;
         fill_type_reg    <= 2'd0;
         fill_payload_reg <= '0;
         ptr_reg          <= 2'd0;
         cnt_reg          <= '0;
      end else begin
         if (grant) begin
            fill_v_reg       <= 1'b1;
            fill_type_reg    <= grant_idx;
            fill_payload_reg <= sel_payload;
            ptr_reg          <= (grant_idx == 2'd2) ? 2'd0 : grant_idx + 2'd1;
            if (cnt_reg != {cnt_width_p{1'b1}})
               cnt_reg <= cnt_reg + cnt_width_p'(1);
         end else if (fill_ready_i) begin
            // Payload and type keep their old values; only valid drops.
            fill_v_reg <= 1'b0;
         end
      end
   end

   assign fill_o      = fill_payload_reg;
   assign fill_type_o = fill_type_reg;
   assign fill_v_o    = fill_v_reg;
   assign grant_cnt_o = cnt_reg;
   assign idle_o      = ~fill_v_reg & ~(|valid_vec);

endmodule

// File: tb/tb_bp_fe_fill_arbiter.sv
// Self-checking bench for bp_fe_fill_arbiter. A reference model of the
// round-robin pointer and grant counter predicts each cycle's accepts. The
// accepted packets go into a scoreboard queue. That queue is compared
// against the fill port while the holding register is valid.
module tb_bp_fe_fill_arbiter;

   localparam int DW = 522;
   localparam int TW = 40;
   localparam int SW = 12;
   localparam int FW = 522;
   localparam int CW = 4;
   localparam int CW_MAX = 15;
   localparam int XW = 528;

   typedef struct {
      logic [1:0]    t;
      logic [FW-1:0] p;
   } exp_t;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic [DW-1:0] data_pkt = '0;
   logic          data_v = 1'b0;
   logic          data_rdy;
   logic [TW-1:0] tag_pkt = '0;
   logic          tag_v = 1'b0;
   logic          tag_rdy;
   logic [SW-1:0] stat_pkt = '0;
   logic          stat_v = 1'b0;
   logic          stat_rdy;
   logic          quiesce = 1'b0;
   logic [FW-1:0] fill;
   logic [1:0]    fill_type;
   logic          fill_v;
   logic          fill_ready = 1'b0;
   logic [CW-1:0] grant_cnt;
   logic          idle;

   exp_t sb[$];
   int   m_ptr = 0;
   int   m_cnt = 0;
   int   n_chk = 0;
   int   n_fail = 0;

   bp_fe_fill_arbiter #(
      .data_pkt_width_p (DW),
      .tag_pkt_width_p  (TW),
      .stat_pkt_width_p (SW),
      .cnt_width_p      (CW)
   ) dut (
      .clk_i            (clk),
      .reset_n_i        (reset_n),
      .data_pkt_i       (data_pkt),
      .data_pkt_v_i     (data_v),
      .data_pkt_ready_o (data_rdy),
      .tag_pkt_i        (tag_pkt),
      .tag_pkt_v_i      (tag_v),
      .tag_pkt_ready_o  (tag_rdy),
      .stat_pkt_i       (stat_pkt),
      .stat_pkt_v_i     (stat_v),
      .stat_pkt_ready_o (stat_rdy),
      .quiesce_i        (quiesce),
      .fill_o           (fill),
      .fill_type_o      (fill_type),
      .fill_v_o         (fill_v),
      .fill_ready_i     (fill_ready),
      .grant_cnt_o      (grant_cnt),
      .idle_o           (idle)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [XW-1:0] obs, input logic [XW-1:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic dv, input logic tv, input logic sv,
                        input logic fr, input logic qu);
      data_v     = dv;
      tag_v      = tv;
      stat_v     = sv;
      fill_ready = fr;
      quiesce    = qu;
      for (int i = 0; i < DW; i++) data_pkt[i] = 1'($urandom_range(1, 0));
      tag_pkt  = {8'($urandom), $urandom};
      stat_pkt = 12'($urandom);
   endtask

   // One clock: check outputs at the falling edge, then advance the model.
   task automatic cycle();
      logic       hv;
      logic       en;
      logic [2:0] vld;
      logic [2:0] exp_rdy;
      int         g;
      exp_t       e;
      @(negedge clk);
      hv = (sb.size() != 0);
      check("fill_v", XW'(fill_v), XW'(hv));
      if (hv) begin
         check("fill_type", XW'(fill_type), XW'(sb[0].t));
         check("fill_o", XW'(fill), XW'(sb[0].p));
      end
      vld = {stat_v, tag_v, data_v};
      check("idle", XW'(idle), XW'(!hv && vld == 3'b000));
      check("grant_cnt", XW'(grant_cnt), XW'(m_cnt));
      en = (!hv || fill_ready) && !quiesce;
      g = -1;
      if (en) begin
         for (int k = 0; k < 3; k++) begin
            int idx;
            idx = (m_ptr + k) % 3;
            if (g < 0 && vld[idx]) g = idx;
         end
      end
      exp_rdy = 3'b000;
      e.t = 2'd0;
      e.p = '0;
      if (g >= 0) begin
         exp_rdy[g] = 1'b1;
         e.t = 2'(g);
         if (g == 0) e.p = data_pkt;
         else if (g == 1) e.p[TW-1:0] = tag_pkt;
         else e.p[SW-1:0] = stat_pkt;
      end
      check("ready", XW'({stat_rdy, tag_rdy, data_rdy}), XW'(exp_rdy));
      @(posedge clk);
      #1;
      if (hv && fill_ready) void'(sb.pop_front());
      if (g >= 0) begin
         sb.push_back(e);
         m_ptr = (g + 1) % 3;
         if (m_cnt < CW_MAX) m_cnt++;
         $display("t=%0t grant ch=%0d cnt=%0d", $time, g, m_cnt);
      end
   endtask

   initial begin
      // Reset held: accepts must stay low even with valids asserted.
      drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      #12;
      check("rst_ready", XW'({stat_rdy, tag_rdy, data_rdy}), XW'(0));
      check("rst_fill_v", XW'(fill_v), XW'(0));
      @(posedge clk);
      #1;
      drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      reset_n = 1'b1;
      cycle();

      // Round robin with all channels valid.
      for (int i = 0; i < 6; i++) begin
         drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
         cycle();
      end
      check("rr_cnt", XW'(grant_cnt), XW'(6));

      // Single tag packet latency.
      drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      tag_pkt = 40'h12_3456_789A;
      cycle();
      drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      check("lat_fill_o", XW'(fill), XW'(40'h12_3456_789A));
      check("lat_type", XW'(fill_type), XW'(1));
      cycle();

      // Backpressure: data A held while stat waits.
      drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      cycle();
      for (int i = 0; i < 5; i++) begin
         drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
         cycle();
      end
      drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      cycle();
      drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      cycle();

      // Quiesce: held fill drains, no new grant until release.
      drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      cycle();
      for (int i = 0; i < 2; i++) begin
         drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
         cycle();
      end
      drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      cycle();

      // Asynchronous reset mid-cycle while a fill is held.
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      #2;
      check("pre_arst_fill_v", XW'(fill_v), XW'(1));
      reset_n = 1'b0;
      #1;
      check("arst_fill_v", XW'(fill_v), XW'(0));
      check("arst_fill_o", XW'(fill), XW'(0));
      check("arst_cnt", XW'(grant_cnt), XW'(0));
      data_v = 1'b1;
      fill_ready = 1'b1;
      #1;
      check("arst_ready", XW'({stat_rdy, tag_rdy, data_rdy}), XW'(0));
      sb.delete();
      m_ptr = 0;
      m_cnt = 0;
      @(posedge clk);
      #1;
      drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      reset_n = 1'b1;
      cycle();

      // Random traffic; also pushes the 4-bit counter well into saturation.
      for (int i = 0; i < 80; i++) begin
         drive(1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
               1'($urandom_range(3, 0) != 0), 1'($urandom_range(4, 0) == 0));
         cycle();
      end
      for (int i = 0; i < 20; i++) begin
         drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
         cycle();
      end
      check("sat_cnt", XW'(grant_cnt), XW'(CW_MAX));

      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end

endmodule
